// File: rtl/crc_calc_if.sv
// CRC engine handshake and data bus between the sequencing FSM (master) and crc_calc (slave).
interface crc_calc_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 16
);
  logic              crc_start;
  logic              crc_en;
  logic              crc_rdy;
  logic [DATA_W-1:0] mem_data;
  logic [CRC_W-1:0]  crc_ref;
  logic [CRC_W-1:0]  crc_value;
  logic [10:0]       word_cnt;
  logic              crc_done;
  logic              crc_ok;
  logic              crc_fail;

  modport master (
    output crc_start, crc_en, crc_rdy, mem_data, crc_ref,
    input  crc_value, word_cnt, crc_done, crc_ok, crc_fail
  );

  modport slave (
    input  crc_start, crc_en, crc_rdy, mem_data, crc_ref,
    output crc_value, word_cnt, crc_done, crc_ok, crc_fail
  );
endinterface

// File: rtl/crc_calc.sv
// Byte-wise non-reflected CRC engine: absorbs one word per crc_en, counts words,
// and latches a done/ok/fail verdict after the sweep until the next crc_start.
module crc_calc #(
  parameter int unsigned          DATA_W  = 8,
  parameter int unsigned          CRC_W   = 16,
  parameter logic [CRC_W-1:0]     POLY    = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0]     INIT    = CRC_W'(16'hFFFF),
  parameter int unsigned          N_WORDS = 1024
) (
  input  logic       clk50m,
  input  logic       rst_n,
  crc_calc_if.slave  bus
);

  localparam int unsigned       CNT_W = 11;
  localparam logic [CNT_W-1:0]  N_CNT = CNT_W'(N_WORDS);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_ACCUM  = 3'b001;
  localparam logic [2:0] S_CHECK  = 3'b010;
  localparam logic [2:0] S_RESULT = 3'b100;

  logic [2:0]       state_q, state_d;
  logic [CRC_W-1:0] crc_value_q, crc_value_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             crc_done_q, crc_done_d;
  logic             crc_ok_q, crc_ok_d;
  logic             crc_fail_q, crc_fail_d;
  logic             overrun_q, overrun_d;
  logic             start_run;
  logic             match;

  // Serial MSB-first shift register, unrolled over one data word.
  function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] crc_in,
                                                  input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    crc_value_d = crc_value_q;
    word_cnt_d  = word_cnt_q;
    crc_done_d  = crc_done_q;
    crc_ok_d    = crc_ok_q;
    crc_fail_d  = crc_fail_q;
    overrun_d   = overrun_q;
    start_run   = 1'b0;
    match       = (crc_value_q == bus.crc_ref) && (word_cnt_q == N_CNT) && !overrun_q;

    case (state_q)
      S_IDLE: begin
        if (bus.crc_start) start_run = 1'b1;
      end
      S_ACCUM: begin
        if (bus.crc_start) begin
          start_run = 1'b1;
        end else begin
          // Words beyond the expected length are dropped and flag an overrun.
          if (bus.crc_en) begin
            if (word_cnt_q < N_CNT) begin
              crc_value_d = crc_update(crc_value_q, bus.mem_data);
              word_cnt_d  = CNT_W'(word_cnt_q + CNT_W'(1));
            end else begin
              overrun_d = 1'b1;
            end
          end
          if (bus.crc_rdy) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bus.crc_start) begin
          start_run = 1'b1;
        end else begin
          crc_done_d = 1'b1;
          crc_ok_d   = match;
          crc_fail_d = !match;
          state_d    = S_RESULT;
        end
      end
      S_RESULT: begin
        if (bus.crc_start) start_run = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        crc_value_d = INIT;
        word_cnt_d  = '0;
        crc_done_d  = 1'b0;
        crc_ok_d    = 1'b0;
        crc_fail_d  = 1'b0;
        overrun_d   = 1'b0;
      end
    endcase

    // A new run wipes everything, including any coincident crc_en word.
    if (start_run) begin
      state_d     = S_ACCUM;
      crc_value_d = INIT;
      word_cnt_d  = '0;
      crc_done_d  = 1'b0;
      crc_ok_d    = 1'b0;
      crc_fail_d  = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      crc_value_q <= INIT;
      word_cnt_q  <= '0;
      crc_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_fail_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_value_q <= crc_value_d;
      word_cnt_q  <= word_cnt_d;
      crc_done_q  <= crc_done_d;
      crc_ok_q    <= crc_ok_d;
      crc_fail_q  <= crc_fail_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.crc_value = crc_value_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.crc_done  = crc_done_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.crc_fail  = crc_fail_q;

endmodule

// File: tb/tb_crc_calc.sv
// Directed bench for crc_calc: three instances (N_WORDS = 9, 1, 1024) share one stimulus stream.
module tb_crc_calc;

  logic        clk50m = 1'b0;
  logic        rst_n;
  logic        start, en, rdy;
  logic [7:0]  data;
  logic [15:0] cref;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #10 clk50m = ~clk50m;

  crc_calc_if #(.DATA_W(8), .CRC_W(16)) if9  ();
  crc_calc_if #(.DATA_W(8), .CRC_W(16)) if1  ();
  crc_calc_if #(.DATA_W(8), .CRC_W(16)) if1k ();

  assign if9.crc_start  = start;  assign if9.crc_en  = en;  assign if9.crc_rdy  = rdy;
  assign if9.mem_data   = data;   assign if9.crc_ref  = cref;
  assign if1.crc_start  = start;  assign if1.crc_en  = en;  assign if1.crc_rdy  = rdy;
  assign if1.mem_data   = data;   assign if1.crc_ref  = cref;
  assign if1k.crc_start = start;  assign if1k.crc_en = en;  assign if1k.crc_rdy = rdy;
  assign if1k.mem_data  = data;   assign if1k.crc_ref = cref;

  crc_calc #(.N_WORDS(9))    u9  (.clk50m(clk50m), .rst_n(rst_n), .bus(if9));
  crc_calc #(.N_WORDS(1))    u1  (.clk50m(clk50m), .rst_n(rst_n), .bus(if1));
  crc_calc #(.N_WORDS(1024)) u1k (.clk50m(clk50m), .rst_n(rst_n), .bus(if1k));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk50m) start = 1'b1;
    @(negedge clk50m) start = 1'b0;
  endtask

  // FETCH/WAIT/PROCESS cadence: one crc_en every third cycle.
  task automatic absorb(input logic [7:0] b);
    @(negedge clk50m) begin data = b; en = 1'b1; end
    @(negedge clk50m) en = 1'b0;
    @(negedge clk50m);
  endtask

  task automatic absorb_digits(input int n);
    for (int i = 0; i < n; i++) absorb(8'(8'h31 + i));
  endtask

  // Leaves the bench at the negedge after CHECK, i.e. two edges after crc_rdy.
  task automatic finish_run(input logic [15:0] r);
    @(negedge clk50m) begin rdy = 1'b1; cref = r; end
    @(negedge clk50m) rdy = 1'b0;
    @(negedge clk50m);
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  logic [15:0] img_crc;

  initial begin
    rst_n = 1'b0; start = 1'b0; en = 1'b0; rdy = 1'b0; data = '0; cref = '0;
    repeat (3) @(negedge clk50m);
    rst_n = 1'b1;
    @(negedge clk50m);
    chk("reset_value", 32'(if9.crc_value), 32'hFFFF);
    chk("reset_cnt",   32'(if9.word_cnt), 32'd0);
    chk("reset_flags", 32'({if9.crc_done, if9.crc_ok, if9.crc_fail}), 32'b000);

    // "123456789" check vector
    pulse_start();
    absorb_digits(9);
    chk("vec_value", 32'(if9.crc_value), 32'h29B1);
    chk("vec_cnt",   32'(if9.word_cnt), 32'd9);
    finish_run(16'h29B1);
    chk("vec_flags", 32'({if9.crc_done, if9.crc_ok, if9.crc_fail}), 32'b110);

    // Single zero byte, wrong then right reference
    pulse_start();
    chk("restart_flags", 32'({if9.crc_done, if9.crc_ok, if9.crc_fail}), 32'b000);
    absorb(8'h00);
    chk("one_value", 32'(if1.crc_value), 32'hE1F0);
    finish_run(16'hE1F1);
    chk("one_bad_flags", 32'({if1.crc_done, if1.crc_ok, if1.crc_fail}), 32'b101);
    absorb(8'h5A);
    chk("result_hold", 32'(if1.crc_value), 32'hE1F0);
    pulse_start();
    absorb(8'h00);
    finish_run(16'hE1F0);
    chk("one_ok_flags", 32'({if1.crc_done, if1.crc_ok, if1.crc_fail}), 32'b110);

    // Short run
    pulse_start();
    absorb_digits(8);
    finish_run(16'h29B1);
    chk("short_cnt",   32'(if9.word_cnt), 32'd8);
    chk("short_flags", 32'({if9.crc_done, if9.crc_ok, if9.crc_fail}), 32'b101);

    // Overrun: tenth word discarded, verdict still fails
    pulse_start();
    absorb_digits(9);
    absorb(8'h55);
    chk("ovr_value", 32'(if9.crc_value), 32'h29B1);
    chk("ovr_cnt",   32'(if9.word_cnt), 32'd9);
    finish_run(16'h29B1);
    chk("ovr_flags", 32'({if9.crc_done, if9.crc_ok, if9.crc_fail}), 32'b101);

    // crc_en coincident with crc_rdy on the last word
    pulse_start();
    absorb_digits(8);
    @(negedge clk50m) begin data = 8'h39; en = 1'b1; rdy = 1'b1; cref = 16'h29B1; end
    @(negedge clk50m) begin en = 1'b0; rdy = 1'b0; end
    @(negedge clk50m);
    chk("coinc_value", 32'(if9.crc_value), 32'h29B1);
    chk("coinc_flags", 32'({if9.crc_done, if9.crc_ok, if9.crc_fail}), 32'b110);

    // crc_start coincident with crc_en: the word is not absorbed
    @(negedge clk50m) begin start = 1'b1; en = 1'b1; data = 8'h31; end
    @(negedge clk50m) begin start = 1'b0; en = 1'b0; end
    chk("startEn_value", 32'(if9.crc_value), 32'hFFFF);
    chk("startEn_cnt",   32'(if9.word_cnt), 32'd0);
    chk("startEn_flags", 32'({if9.crc_done, if9.crc_ok, if9.crc_fail}), 32'b000);

    // Asynchronous reset in the middle of ACCUM
    absorb_digits(3);
    chk("mid_cnt", 32'(if9.word_cnt), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("async_value", 32'(if9.crc_value), 32'hFFFF);
    chk("async_cnt",   32'(if9.word_cnt), 32'd0);
    chk("async_flags", 32'({if9.crc_done, if9.crc_ok, if9.crc_fail}), 32'b000);
    @(negedge clk50m) rst_n = 1'b1;

    // Full 1024-byte image, run twice from start and from RESULT
    img_crc = 16'hFFFF;
    for (int i = 0; i < 1024; i++) img_crc = model_step(img_crc, 8'(i * 7 + 3));
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      for (int i = 0; i < 1024; i++) absorb(8'(i * 7 + 3));
      finish_run(img_crc);
      chk($sformatf("img%0d_value", pass), 32'(if1k.crc_value), 32'(img_crc));
      chk($sformatf("img%0d_cnt", pass),   32'(if1k.word_cnt), 32'd1024);
      chk($sformatf("img%0d_flags", pass), 32'({if1k.crc_done, if1k.crc_ok, if1k.crc_fail}), 32'b110);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_calc.md
# crc_calc

Byte-wise CRC-16 engine downstream of the CRC sequencing FSM. It absorbs one memory word per `crc_en` strobe and counts the words absorbed. On `crc_rdy` it checks the accumulated CRC against a reference value and the word count against the expected length, then holds a done/ok/fail verdict until the next `crc_start`.

## Interface
- `DATA_W`, default 8: memory word width, processed MSB first.
- `CRC_W`, default 16: CRC register width.
- `POLY`, default 16'h1021: generator polynomial (CCITT), non-reflected.
- `INIT`, default 16'hFFFF: CRC preset value; there is no final XOR.
- `N_WORDS`, default 1024: expected number of words per run.

- `clk50m`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `crc_start`  in  1  begin a new run; clears the CRC and the counter.
- `crc_en`  in  1  absorb `mem_data` on this edge; single-cycle strobe from the FSM.
- `crc_rdy`  in  1  FSM has finished the memory sweep (level).
- `mem_data`  in  DATA_W  memory read data; valid whenever `crc_en`=1.
- `crc_ref`  in  CRC_W  expected CRC; sampled in CHECK.
- `crc_value`  out  CRC_W  running/final CRC register.
- `word_cnt`  out  11  words absorbed in the current run; saturates at N_WORDS.
- `crc_done`  out  1  verdict valid (state RESULT).
- `crc_ok`  out  1  CRC matched and count = N_WORDS.
- `crc_fail`  out  1  CRC mismatch, count ≠ N_WORDS, or overrun.

## Operation
- Reset values:
  - state = IDLE.
  - `crc_value` = INIT; `word_cnt` = 0.
  - `crc_done`, `crc_ok`, `crc_fail` = 0; internal overrun flag = 0.
- CRC update, per absorbed word:
  - Eight serial steps unrolled combinationally, starting from the MSB of `mem_data`.
  - Each step: `fb = crc[15] ^ d[i]`, then `crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0)`.
- IDLE:
  - `crc_en` and `crc_rdy` are ignored.
  - On `crc_start`: go to ACCUM; `crc_value` = INIT; `word_cnt` = 0; overrun = 0.
- ACCUM:
  - Every `crc_en` with `word_cnt` < N_WORDS: update `crc_value` and increment `word_cnt`.
  - Every `crc_en` with `word_cnt` = N_WORDS: data is discarded, `word_cnt` holds, overrun = 1.
  - `crc_rdy`=1 moves the state to CHECK.
- CHECK (one cycle):
  - `crc_ok` = (`crc_value` == `crc_ref`) & (`word_cnt` == N_WORDS) & !overrun.
  - `crc_fail` = !`crc_ok`.
  - Then go to RESULT.
- RESULT:
  - `crc_done`=1; `crc_value`, `word_cnt`, `crc_ok` and `crc_fail` are held.
  - `crc_en` and `crc_rdy` are ignored.
  - On `crc_start`: go to ACCUM and clear exactly as from IDLE; `crc_done`, `crc_ok` and `crc_fail` drop to 0 on the same edge.
- Priority when events coincide:
  - `crc_start` beats everything else. In any state, `crc_start` clears and enters ACCUM, and a coincident `crc_en` word is not absorbed.
  - In ACCUM, a coincident `crc_en` and `crc_rdy` means the word is absorbed first, then the state goes to CHECK. The CHECK compare sees the updated value.
- The unused state encoding returns to IDLE with reset output values.
- Reset asserted mid-run forces all reset values immediately, asynchronously; no verdict is produced.

## Timing
- `crc_value` and `word_cnt` reflect a word one cycle after the edge at which `crc_en`=1.
- Compatibility with the FSM's FETCH → WAIT → PROCESS cadence:
  - Memory data is valid two cycles after the address update, which is the same cycle as `crc_en`.
  - One word is therefore absorbed every 3 cycles.
- Verdict latency:
  - Edge k: ACCUM sees `crc_rdy`=1.
  - Edge k+1: CHECK.
  - `crc_done`, `crc_ok` and `crc_fail` are valid after edge k+1 and remain stable until `crc_start` or reset.
- `crc_ok` and `crc_fail` are mutually exclusive, and both are 0 whenever `crc_done`=0.
- `crc_ref` must be stable during the CHECK cycle; it is don't-care at other times.
- Full-length run at N_WORDS=1024:
  - From `crc_start` to `crc_done`: 3×1024 + 1 + 2 cycles nominal, with the FSM upstream.
  - Same run at 20 ns/cycle: about 61.5 µs.

## Test plan
- Reset: hold `rst_n`=0, then release.
  - Required: `crc_value`=16'hFFFF, `word_cnt`=0, `crc_done`/`crc_ok`/`crc_fail`=0.
  - Repeat by asserting `rst_n` mid-ACCUM: outputs return to reset values immediately.
- Known vector, N_WORDS=9: `crc_start`, then bytes "123456789" (8'h31..8'h39) on `crc_en` at the 3-cycle cadence, then `crc_rdy` with `crc_ref`=16'h29B1.
  - Required: `crc_value`=16'h29B1, `word_cnt`=9, `crc_ok`=1 two edges after `crc_rdy`.
- Single word, N_WORDS=1: `crc_start`, then byte 8'h00.
  - Required: `crc_value`=16'hE1F0.
  - Then `crc_rdy` with `crc_ref`=16'hE1F1: `crc_fail`=1, `crc_ok`=0.
- Count errors, N_WORDS=9:
  - Short run: 8 words then `crc_rdy` → `crc_fail`=1, `word_cnt`=8.
  - Overrun: 10 words → `word_cnt` stays 9, the 10th word leaves `crc_value` unchanged, and `crc_fail`=1 even with a matching `crc_ref`.
- Simultaneous events:
  - `crc_en` together with `crc_rdy` on the last word: the word is included and the verdict is correct.
  - `crc_start` together with `crc_en`: `crc_value`=16'hFFFF, `word_cnt`=0.
- Full system, N_WORDS=1024, with the CRC FSM and memory model: `crc_done` rises once per `crc_start`.
  - `crc_value` equals the software model of the 1024-byte image.
  - Restarting from RESULT reproduces the same value.
